// File: rtl/r0_arbiter.sv
// r0_arbiter
//   Round-robin arbiter/sequencer sharing one r0_multiplexer among four
//   requesters (ALU operand fetch, memory load, I/O, PC path). A winning
//   requester's op/a/b lane is latched and driven to the mux. The arbiter
//   waits for mux_ready, captures the mux outputs and returns them with a
//   one-cycle done pulse. A bounded wait keeps a stalled mux from locking
//   the bus.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req[3:0]              level request per requester, held until its done
//   op[7:0]               packed 2-bit mux state per requester {op3..op0}
//   a[31:0], b[31:0]      packed 8-bit value1/value2 per requester
//   gnt[3:0]              one-hot grant, ISSUE through DONE
//   done[3:0]             one-hot one-cycle completion pulse
//   err                   timeout flag, coincident with done
//   rdata1, rdata2        captured mux outputs, held until next capture
//   busy                  FSM not in IDLE
//   mux_en, mux_state, mux_value1, mux_value2   drive the mux
//   mux_ready, mux_out1, mux_out2               from the mux
module r0_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req,
   input  logic [2*NREQ-1:0]   op,
   input  logic [8*NREQ-1:0]   a,
   input  logic [8*NREQ-1:0]   b,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     done,
   output logic                err,
   output logic [7:0]          rdata1,
   output logic [7:0]          rdata2,
   output logic                busy,
   output logic                mux_en,
   output logic [1:0]          mux_state,
   output logic [7:0]          mux_value1,
   output logic [7:0]          mux_value2,
   input  logic                mux_ready,
   input  logic [7:0]          mux_out1,
   input  logic [7:0]          mux_out2
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   logic [1:0] state;
   logic [1:0] idx;
   logic [1:0] last;
   logic [1:0] op_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [7:0] cnt;
   logic       tmo;

   logic [1:0]      pick;
   logic [1:0]      cand;
   logic [NREQ-1:0] idx_oh;

   // Scan last+4 (== last) down to last+1 so the candidate closest after
   // 'last' overwrites the others and wins: strict rotation.
   always_comb begin
      pick = '0;
      cand = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = last + 2'(i);
         if (req[cand]) pick = cand;
      end
   end

   always_comb begin
      idx_oh      = '0;
      idx_oh[idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= '0;
         last   <= 2'd3;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         cnt    <= '0;
         tmo    <= 1'b0;
         rdata1 <= '0;
         rdata2 <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  idx   <= pick;
                  op_q  <= op[{pick, 1'b0} +: 2];
                  a_q   <= a[{pick, 3'b000} +: 8];
                  b_q   <= b[{pick, 3'b000} +: 8];
                  cnt   <= '0;
                  tmo   <= 1'b0;
                  state <= S_ISSUE;
               end
            end
            // mux_ready is deliberately not looked at here: the mux has
            // only just seen en and any ready now is stale.
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (mux_ready) begin
                  rdata1 <= mux_out1;
                  rdata2 <= mux_out2;
                  state  <= S_DONE;
               end else if (cnt == TMO) begin
                  tmo   <= 1'b1;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               last  <= idx;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = (state != S_IDLE);
   assign mux_en = (state == S_ISSUE) || (state == S_WAIT);
   assign gnt    = busy ? idx_oh : '0;
   assign done   = (state == S_DONE) ? idx_oh : '0;
   assign err    = (state == S_DONE) && tmo;

   // Mux inputs are forced to zero outside ISSUE/WAIT so nothing stale
   // leaks to the mux while it is disabled.
   assign mux_state  = mux_en ? op_q : '0;
   assign mux_value1 = mux_en ? a_q  : '0;
   assign mux_value2 = mux_en ? b_q  : '0;

endmodule

// File: tb/tb_r0_arbiter.sv
module tb_r0_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        err;
   logic [7:0]  rdata1;
   logic [7:0]  rdata2;
   logic        busy;
   logic        mux_en;
   logic [1:0]  mux_state;
   logic [7:0]  mux_value1;
   logic [7:0]  mux_value2;
   logic        mux_ready;
   logic [7:0]  mux_out1;
   logic [7:0]  mux_out2;

   r0_arbiter #(.NREQ(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
      .gnt(gnt), .done(done), .err(err), .rdata1(rdata1), .rdata2(rdata2),
      .busy(busy), .mux_en(mux_en), .mux_state(mux_state),
      .mux_value1(mux_value1), .mux_value2(mux_value2),
      .mux_ready(mux_ready), .mux_out1(mux_out1), .mux_out2(mux_out2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Mux model. mode 0: never ready; 1: ready one cycle after en;
   // 2: ready tied high. Outputs are the values XORed with a key so a
   // capture of the wrong bus is visible.
   int         mode = 1;
   logic       mr = 1'b0;
   logic [7:0] xk1 = 8'h00;
   logic [7:0] xk2 = 8'h00;
   always @(posedge clk) begin
      case (mode)
         0:       mr <= 1'b0;
         1:       mr <= mux_en & ~mr;
         default: mr <= 1'b1;
      endcase
   end
   assign mux_ready = mr;
   assign mux_out1  = mux_value1 ^ xk1;
   assign mux_out2  = mux_value2 ^ xk2;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] idx;
      logic [7:0] r1;
      logic [7:0] r2;
      logic       err;
      int         cyc;
   } exp_t;
   exp_t q[$];

   task automatic push(input logic [1:0] idx, input logic [7:0] r1, input logic [7:0] r2,
                       input logic e, input int c);
      exp_t x;
      x.idx = idx; x.r1 = r1; x.r2 = r2; x.err = e; x.cyc = c;
      q.push_back(x);
   endtask

   // Scoreboard monitor
   exp_t       e;
   logic [3:0] oh;
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done !== 4'b0) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e  = q.pop_front();
            oh = 4'b0001 << e.idx;
            chk("done_onehot", 32'(done), 32'(oh));
            chk("done_err", 32'(err), 32'(e.err));
            chk("rdata1", 32'(rdata1), 32'(e.r1));
            chk("rdata2", 32'(rdata2), 32'(e.r2));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic set_lane(input int i, input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv);
      op[2*i +: 2] = o;
      a[8*i +: 8]  = av;
      b[8*i +: 8]  = bv;
   endtask

   // Wait for n done pulses (bounded), dropping req on the last one.
   task automatic wait_dones(input int n, input string tag);
      int got = 0;
      for (int t = 0; t < 300 && got < n; t++) begin
         @(negedge clk);
         if (done !== 4'b0) begin
            got++;
            chk({tag, "_en_in_done"}, 32'(mux_en), 32'd0);
         end
      end
      req = 4'b0;
      chk({tag, "_done_count"}, 32'(got), 32'(n));
   endtask

   int c;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with all requesters active
      rst_n = 1'b0; req = 4'b1111; op = '0; a = '0; b = '0;
      for (int i = 0; i < 4; i++) set_lane(i, 2'(3 - i), 8'(8'h10 + i), 8'(8'h20 + i));
      mode = 1; xk1 = 8'h80; xk2 = 8'h01;
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mux_en", 32'(mux_en), 0);
      chk("rst_mux_bus", {14'd0, mux_state, mux_value1, mux_value2}, 0);
      chk("rst_rdata", {16'd0, rdata1, rdata2}, 0);

      // Round-robin with req held: 0,1,2,3,0
      c = cyc;
      push(2'd0, 8'h90, 8'h21, 1'b0, c + 3);
      push(2'd1, 8'h91, 8'h20, 1'b0, c + 7);
      push(2'd2, 8'h92, 8'h23, 1'b0, c + 11);
      push(2'd3, 8'h93, 8'h22, 1'b0, c + 15);
      push(2'd0, 8'h90, 8'h21, 1'b0, c + 19);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_gnt", 32'(gnt), 32'h1);
      chk("first_busy", 32'(busy), 1);
      chk("first_mux_en", 32'(mux_en), 1);
      chk("first_state", 32'(mux_state), 3);
      chk("first_v1", 32'(mux_value1), 32'h10);
      chk("first_v2", 32'(mux_value2), 32'h20);
      wait_dones(5, "rr");
      repeat (2) @(negedge clk);
      chk("rr_idle_busy", 32'(busy), 0);
      chk("rr_idle_gnt", 32'(gnt), 0);

      // Single transaction on requester 1, then scribble the inputs
      mode = 1; xk1 = 8'h00; xk2 = 8'h00;
      set_lane(1, 2'd1, 8'd1, 8'd2);
      req = 4'b0010; c = cyc;
      push(2'd1, 8'd1, 8'd2, 1'b0, c + 3);
      @(negedge clk);
      chk("iss_gnt", 32'(gnt), 32'h2);
      chk("iss_en", 32'(mux_en), 1);
      chk("iss_state", 32'(mux_state), 1);
      chk("iss_v1", 32'(mux_value1), 1);
      chk("iss_v2", 32'(mux_value2), 2);
      set_lane(1, 2'd2, 8'hEE, 8'hEE);
      @(negedge clk);
      chk("wait_state_latched", 32'(mux_state), 1);
      chk("wait_v1_latched", 32'(mux_value1), 1);
      wait_dones(1, "single");
      @(negedge clk);
      chk("single_rdata_held", {16'd0, rdata1, rdata2}, 32'h0102);
      chk("single_busy", 32'(busy), 0);

      // Timeout on requester 2: rdata keeps 1/2
      mode = 0;
      set_lane(2, 2'd2, 8'h77, 8'h88);
      req = 4'b0100; c = cyc;
      push(2'd2, 8'd1, 8'd2, 1'b1, c + 18);
      wait_dones(1, "tmo");
      @(negedge clk);
      chk("tmo_err_one_cycle", 32'(err), 0);

      // Ready high during ISSUE is ignored; req withdrawn in WAIT
      mode = 2; xk1 = 8'h5A; xk2 = 8'h3C;
      set_lane(3, 2'd2, 8'h33, 8'h44);
      req = 4'b1000; c = cyc;
      push(2'd3, 8'h69, 8'h78, 1'b0, c + 3);
      @(negedge clk);
      @(negedge clk);
      req = 4'b0000;
      wait_dones(1, "rdyiss");
      mode = 1; xk1 = 8'h00; xk2 = 8'h00;

      // Fairness after last=3: requester 0 then 3
      @(negedge clk);
      set_lane(0, 2'd1, 8'hA0, 8'hB0);
      set_lane(3, 2'd2, 8'hA3, 8'hB3);
      req = 4'b1001; c = cyc;
      push(2'd0, 8'hA0, 8'hB0, 1'b0, c + 3);
      push(2'd3, 8'hA3, 8'hB3, 1'b0, c + 7);
      wait_dones(2, "fair");

      // Reset in the middle of WAIT
      @(negedge clk);
      mode = 0;
      set_lane(1, 2'd1, 8'h05, 8'h06);
      req = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      chk("mid_wait_en", 32'(mux_en), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_en", 32'(mux_en), 0);
      chk("mid_rst_gnt", 32'(gnt), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_rdata", 32'(rdata1), 0);
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", 32'(busy), 0);

      // last reset to 3: requester 1 before 3
      mode = 1;
      set_lane(1, 2'd0, 8'h11, 8'h22);
      set_lane(3, 2'd3, 8'h31, 8'h32);
      req = 4'b1010; c = cyc;
      push(2'd1, 8'h11, 8'h22, 1'b0, c + 3);
      push(2'd3, 8'h31, 8'h32, 1'b0, c + 7);
      wait_dones(2, "post_rst");

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
